weight_buffer_pingpong: RTL

Double-buffered weight store feeding the PE-array tap registers. Each PE column owns a two-bank weight memory. The write port fills one bank through a valid/ready stream while the array consumes the other. A load sequencer fetches `nb_taps` consecutive weights per column from the active bank into the tap registers. This block is the next-generation replacement for the single-bank, externally addressed weight buffer: it adds bank swapping, a fill handshake and automatic tap sequencing.

---
 rtl/weight_buffer_pingpong_if.sv | 14 +
 rtl/weight_buffer_pingpong.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/weight_buffer_pingpong_if.sv
// Weight fill stream: one word per column per beat, valid/ready handshake
// with an end-of-fill marker.
interface weight_buffer_pingpong_if #(
  parameter int nb_pe_col    = 32,
  parameter int weight_width = 16
);
  logic                              wr_valid;
  logic                              wr_ready;
  logic [nb_pe_col*weight_width-1:0] wr_data;
  logic                              wr_last;

  modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface

// File: rtl/weight_buffer_pingpong.sv
// Two-bank per-column weight store: one bank fills through a stream while the
// other feeds the tap registers through an automatic load sequencer.
module weight_buffer_pingpong #(
  parameter int nb_pe_col    = 32,
  parameter int nb_taps      = 5,
  parameter int weight_width = 16,
  parameter int bank_depth   = 64,
  parameter int addr_width   = $clog2(bank_depth)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  weight_buffer_pingpong_if.slave                   wr,
  input  logic                                      ld_start,
  input  logic [addr_width-1:0]                     ld_base,
  output logic                                      ld_busy,
  output logic                                      ld_done,
  input  logic                                      bank_release,
  output logic                                      rd_bank_full,
  output logic [nb_pe_col*nb_taps*weight_width-1:0] WRegs
);

  localparam int word_w = nb_pe_col * weight_width;
  localparam int tap_w  = (nb_taps > 1) ? $clog2(nb_taps) : 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} ld_state_t;

  function automatic logic [addr_width-1:0] wrap_inc(input logic [addr_width-1:0] a);
    if (a == addr_width'(bank_depth - 1)) return '0;
    return a + 1'b1;
  endfunction

  logic [word_w-1:0]     mem [2][bank_depth];

  logic [1:0]            full;
  logic [1:0]            full_nxt;
  logic                  fill_sel;
  logic                  read_sel;
  logic [addr_width-1:0] wr_ptr;
  logic [addr_width-1:0] rd_addr;
  logic [tap_w-1:0]      tap_cnt;
  ld_state_t             state;

  logic                  wr_acc;
  logic                  wr_end;
  logic                  rel_ok;
  logic                  start_ok;

  logic [word_w-1:0]     rd_data_p1;
  logic [tap_w-1:0]      tap_p1;
  logic                  vld_p1;

  assign wr.wr_ready   = !full[fill_sel];
  assign wr_acc        = wr.wr_valid && wr.wr_ready;
  assign wr_end        = wr_acc && (wr.wr_last || (wr_ptr == addr_width'(bank_depth - 1)));
  assign rel_ok        = bank_release && (state == IDLE) && full[read_sel];
  assign start_ok      = ld_start && (state == IDLE) && full[read_sel];
  assign rd_bank_full  = full[read_sel];

  // Completion and release never target the same bank, so both may apply.
  always_comb begin
    full_nxt = full;
    if (wr_end) full_nxt[fill_sel] = 1'b1;
    if (rel_ok) full_nxt[read_sel] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= '0;
      fill_sel <= 1'b0;
      read_sel <= 1'b0;
      wr_ptr   <= '0;
    end else begin
      full <= full_nxt;
      if (wr_acc) wr_ptr <= wr_end ? '0 : wr_ptr + 1'b1;
      if (wr_end) fill_sel <= !fill_sel;
      if (rel_ok) read_sel <= !read_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[fill_sel][wr_ptr] <= wr.wr_data;
  end

  // Load sequencer: nb_taps reads, one cycle for read latency, one done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tap_cnt <= '0;
      rd_addr <= '0;
      ld_busy <= 1'b0;
      ld_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            state   <= READ;
            rd_addr <= ld_base;
            tap_cnt <= '0;
            ld_busy <= 1'b1;
          end
        end
        READ: begin
          rd_addr <= wrap_inc(rd_addr);
          if (tap_cnt == tap_w'(nb_taps - 1)) state <= DRAIN;
          else tap_cnt <= tap_cnt + 1'b1;
        end
        DRAIN: begin
          state   <= DONE;
          ld_done <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          ld_done <= 1'b0;
          ld_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: synchronous bank read, tap index travels with the data.
  always_ff @(posedge clk) begin
    rd_data_p1 <= mem[read_sel][rd_addr];
    tap_p1     <= tap_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= (state == READ);
  end

  // Stage p2: scatter one word across the columns into tap tap_p1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WRegs <= '0;
    end else if (vld_p1) begin
      for (int i = 0; i < nb_pe_col; i++) begin
        WRegs[(i*nb_taps + int'(tap_p1))*weight_width +: weight_width]
          <= rd_data_p1[i*weight_width +: weight_width];
      end
    end
  end

endmodule
